crossbar_egress_buffer: RTL and testbench

Per-output-port egress stage directly downstream of the crossbar switch.
- Captures each output's 32-bit word in the cycle the crossbar asserts that port's grant bit.
- Queues words in a per-port FIFO and presents them to the downstream consumer over a valid/ready handshake.
- The crossbar has no backpressure input, so this block absorbs bursts, counts words it must drop, and exports a per-port full flag for upstream flow-control logic.

---
 rtl/crossbar_egress_buffer_pkg.sv | 24 ++
 rtl/crossbar_egress_buffer_if.sv | 29 ++
 rtl/crossbar_egress_buffer_egress_port_fifo.sv | 69 ++++++
 rtl/crossbar_egress_buffer.sv | 39 +++
 tb/tb_crossbar_egress_buffer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/crossbar_egress_buffer_pkg.sv
// Shared types and constants for the crossbar egress buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package crossbar_egress_buffer_pkg;
  localparam int M     = 4;   // crossbar output ports
  localparam int W     = 32;  // data word width
  localparam int DEPTH = 4;   // FIFO entries per port, power of two
  localparam int CNT_W = 8;   // drop counter width
  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [W-1:0]     word_t;
  typedef logic [PTR_W-1:0] ptr_t;
  // Count needs one extra bit so that DEPTH itself is representable.
  typedef logic [PTR_W:0]   cnt_t;
  typedef logic [CNT_W-1:0] drop_t;

  localparam cnt_t  CNT_FULL = cnt_t'(DEPTH);
  localparam drop_t DROP_SAT = {CNT_W{1'b1}};

  // Saturating increment for the drop counter.
  function automatic drop_t drop_inc(input drop_t v);
    return (v == DROP_SAT) ? v : v + drop_t'(1);
  endfunction
endpackage

// File: rtl/crossbar_egress_buffer_if.sv
// Bundle of crossbar-side and consumer-side buses for the egress buffer.
// Latency: n/a (wiring only).
// Backpressure: out_valid/out_ready per port; crossbar side has none (full is advisory).
// Ports: grant_in/data_in from the crossbar, out_* to the consumer,
//        full/drop_cnt/overflow as status. All buses are flat, port m at slice m.
interface crossbar_egress_buffer_if;
  import crossbar_egress_buffer_pkg::*;

  logic [M-1:0]       grant_in;
  logic [M*W-1:0]     data_in;
  logic [M-1:0]       out_valid;
  logic [M-1:0]       out_ready;
  logic [M*W-1:0]     out_data;
  logic [M-1:0]       full;
  logic [M*CNT_W-1:0] drop_cnt;
  logic [M-1:0]       overflow;

  // Environment view: drives crossbar data and consumer ready.
  modport master (
    output grant_in, data_in, out_ready,
    input  out_valid, out_data, full, drop_cnt, overflow
  );

  // Buffer view.
  modport slave (
    input  grant_in, data_in, out_ready,
    output out_valid, out_data, full, drop_cnt, overflow
  );
endinterface

// File: rtl/crossbar_egress_buffer_egress_port_fifo.sv
// Single-port FWFT FIFO with drop counter, sticky overflow and full flag.
// Latency: word pushed at edge k is at the head after edge k (no bypass).
// Backpressure: holds head while i_ready low; pushes into a full FIFO without a pop are dropped.
// Ports: clk/rst; i_push/i_data write side; o_valid/i_ready/o_data read side;
//        o_full, o_drop_cnt, o_overflow status.
module egress_port_fifo
  import crossbar_egress_buffer_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_push,
  input  word_t i_data,
  input  logic  i_ready,
  output logic  o_valid,
  output word_t o_data,
  output logic  o_full,
  output drop_t o_drop_cnt,
  output logic  o_overflow
);
  word_t r_mem [DEPTH];
  ptr_t  r_wr_ptr;
  ptr_t  r_rd_ptr;
  cnt_t  r_count;
  drop_t r_drop_cnt;
  logic  r_overflow;

  logic w_pop;
  logic w_wr_en;
  logic w_drop;

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == CNT_FULL);
  assign w_pop   = o_valid & i_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign w_wr_en = i_push & (~o_full | w_pop);
  assign w_drop  = i_push & o_full & ~w_pop;

  // Empty FIFO shows zero rather than stale storage.
  assign o_data     = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_drop_cnt = r_drop_cnt;
  assign o_overflow = r_overflow;

  // Storage needs no reset; contents are masked by the count.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + ptr_t'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + cnt_t'(1);
        2'b01:   r_count <= r_count - cnt_t'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_drop_cnt <= drop_inc(r_drop_cnt);
        r_overflow <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/crossbar_egress_buffer.sv
// Per-output-port egress buffering downstream of the crossbar, one FIFO per port.
// Latency: one cycle from grant to out_valid; first-word-fall-through head.
// Backpressure: per-port valid/ready to consumer; crossbar sees only full, excess words are counted as drops.
// Ports: clk, rst (async, active high); io_egr carries grant_in/data_in,
//        out_valid/out_ready/out_data, full, drop_cnt, overflow as flat M-wide buses.
module crossbar_egress_buffer
  import crossbar_egress_buffer_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  crossbar_egress_buffer_if.slave io_egr
);
  logic [M-1:0]       w_out_valid;
  logic [M-1:0]       w_full;
  logic [M-1:0]       w_overflow;
  logic [M*W-1:0]     w_out_data;
  logic [M*CNT_W-1:0] w_drop_cnt;

  for (genvar g = 0; g < M; g++) begin : g_port
    egress_port_fifo u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (io_egr.grant_in[g]),
      .i_data     (io_egr.data_in[g*W +: W]),
      .i_ready    (io_egr.out_ready[g]),
      .o_valid    (w_out_valid[g]),
      .o_data     (w_out_data[g*W +: W]),
      .o_full     (w_full[g]),
      .o_drop_cnt (w_drop_cnt[g*CNT_W +: CNT_W]),
      .o_overflow (w_overflow[g])
    );
  end

  assign io_egr.out_valid = w_out_valid;
  assign io_egr.out_data  = w_out_data;
  assign io_egr.full      = w_full;
  assign io_egr.drop_cnt  = w_drop_cnt;
  assign io_egr.overflow  = w_overflow;
endmodule

// File: tb/tb_crossbar_egress_buffer.sv
// Testbench for crossbar_egress_buffer: directed scenarios plus random traffic
// against a queue-based reference model of each port.
module tb_crossbar_egress_buffer;
  import crossbar_egress_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  crossbar_egress_buffer_if io();

  crossbar_egress_buffer dut (
    .clk    (clk),
    .rst    (rst),
    .io_egr (io)
  );

  localparam int SAT = (1 << CNT_W) - 1;

  // Reference model: one queue per port plus drop bookkeeping.
  logic [W-1:0] mq [M][$];
  int           mdrop [M];
  bit           movf [M];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_reset();
    for (int m = 0; m < M; m++) begin
      mq[m].delete();
      mdrop[m] = 0;
      movf[m]  = 1'b0;
    end
  endtask

  function automatic logic [M*W-1:0] put(input int m, input logic [W-1:0] w);
    logic [M*W-1:0] b;
    b = '0;
    b[m*W +: W] = w;
    return b;
  endfunction

  // Apply inputs for one clock edge, advance the model, then sample at edge+1.
  task automatic drive(input logic [M-1:0] g, input logic [M*W-1:0] d, input logic [M-1:0] r);
    io.grant_in  = g;
    io.data_in   = d;
    io.out_ready = r;
    @(posedge clk);
    for (int m = 0; m < M; m++) begin
      if (mq[m].size() != 0 && r[m]) void'(mq[m].pop_front());
      if (g[m]) begin
        if (mq[m].size() < DEPTH) mq[m].push_back(d[m*W +: W]);
        else begin
          if (mdrop[m] < SAT) mdrop[m]++;
          movf[m] = 1'b1;
        end
      end
    end
    #1;
    io.grant_in  = '0;
    io.out_ready = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    io.grant_in = '0; io.data_in = '0; io.out_ready = '0;
    #1 rst = 1'b1;
    #20;
    model_reset();
    n_cmp++; if (io.out_valid !== '0) begin n_bad++; $display("FAIL rst_valid: got %h expected 0", io.out_valid); end
    n_cmp++; if (io.full !== '0) begin n_bad++; $display("FAIL rst_full: got %h expected 0", io.full); end
    n_cmp++; if (io.out_data !== '0) begin n_bad++; $display("FAIL rst_data: got %h expected 0", io.out_data); end
    n_cmp++; if (io.drop_cnt !== '0) begin n_bad++; $display("FAIL rst_drop: got %h expected 0", io.drop_cnt); end
    n_cmp++; if (io.overflow !== '0) begin n_bad++; $display("FAIL rst_ovf: got %h expected 0", io.overflow); end
    #1 rst = 1'b0;
    repeat (3) drive('0, '0, '1);
    n_cmp++; if (io.out_valid !== '0 || io.full !== '0 || io.drop_cnt !== '0)
      begin n_bad++; $display("FAIL idle_after_rst: valid %h full %h drop %h expected all 0", io.out_valid, io.full, io.drop_cnt); end
    // Mid-burst asynchronous reset with three words on port 1.
    for (int k = 0; k < 3; k++) drive(4'b0010, put(1, 32'hA0 + k), '0);
    n_cmp++; if (io.out_valid[1] !== 1'b1) begin n_bad++; $display("FAIL burst_valid: got %b expected 1", io.out_valid[1]); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (io.out_valid[1] !== 1'b0) begin n_bad++; $display("FAIL async_rst_valid: got %b expected 0", io.out_valid[1]); end
    n_cmp++; if (io.out_data[1*W +: W] !== '0) begin n_bad++; $display("FAIL async_rst_data: got %h expected 0", io.out_data[1*W +: W]); end
    model_reset();
    #3 rst = 1'b0;
    drive('0, '0, '1);
    n_cmp++; if (io.out_valid !== '0) begin n_bad++; $display("FAIL post_rst_empty: got %h expected 0", io.out_valid); end
  endtask

  task automatic test_single();
    drive(4'b0100, put(2, 32'hDEADBEEF), '1);
    n_cmp++; if (io.out_valid !== 4'b0100) begin n_bad++; $display("FAIL single_valid: got %b expected 0100", io.out_valid); end
    n_cmp++; if (io.out_data[2*W +: W] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_data: got %h expected deadbeef", io.out_data[2*W +: W]); end
    drive('0, '0, '1);
    n_cmp++; if (io.out_valid[2] !== 1'b0) begin n_bad++; $display("FAIL single_popped: got %b expected 0", io.out_valid[2]); end
  endtask

  task automatic test_fill_drop();
    for (int k = 1; k <= 6; k++) begin
      drive(4'b0001, put(0, k), '0);
      if (k == 3) begin
        n_cmp++; if (io.full[0] !== 1'b0) begin n_bad++; $display("FAIL fill_not_full3: got %b expected 0", io.full[0]); end
      end
      if (k == 4) begin
        n_cmp++; if (io.full[0] !== 1'b1) begin n_bad++; $display("FAIL fill_full4: got %b expected 1", io.full[0]); end
        n_cmp++; if (io.overflow[0] !== 1'b0) begin n_bad++; $display("FAIL fill_ovf4: got %b expected 0", io.overflow[0]); end
      end
    end
    n_cmp++; if (io.drop_cnt[0 +: CNT_W] !== 8'd2) begin n_bad++; $display("FAIL fill_drop_cnt: got %0d expected 2", io.drop_cnt[0 +: CNT_W]); end
    n_cmp++; if (io.overflow[0] !== 1'b1) begin n_bad++; $display("FAIL fill_ovf: got %b expected 1", io.overflow[0]); end
    // Holding ready low: head stays put.
    drive('0, '0, '0);
    n_cmp++; if (io.out_data[0 +: W] !== 32'd1) begin n_bad++; $display("FAIL fill_hold: got %0d expected 1", io.out_data[0 +: W]); end
    for (int k = 1; k <= 4; k++) begin
      n_cmp++; if (io.out_valid[0] !== 1'b1 || io.out_data[0 +: W] !== k)
        begin n_bad++; $display("FAIL drain0_%0d: valid %b data %0d expected 1/%0d", k, io.out_valid[0], io.out_data[0 +: W], k); end
      drive('0, '0, 4'b0001);
    end
    n_cmp++; if (io.out_valid[0] !== 1'b0 || io.overflow[0] !== 1'b1)
      begin n_bad++; $display("FAIL drain0_end: valid %b ovf %b expected 0/1", io.out_valid[0], io.overflow[0]); end
  endtask

  task automatic test_full_pushpop();
    for (int k = 10; k <= 13; k++) drive(4'b1000, put(3, k), '0);
    n_cmp++; if (io.full[3] !== 1'b1 || io.out_data[3*W +: W] !== 32'd10)
      begin n_bad++; $display("FAIL pp_full: full %b head %0d expected 1/10", io.full[3], io.out_data[3*W +: W]); end
    drive(4'b1000, put(3, 14), 4'b1000);
    n_cmp++; if (io.drop_cnt[3*CNT_W +: CNT_W] !== '0) begin n_bad++; $display("FAIL pp_drop: got %0d expected 0", io.drop_cnt[3*CNT_W +: CNT_W]); end
    n_cmp++; if (io.full[3] !== 1'b1) begin n_bad++; $display("FAIL pp_still_full: got %b expected 1", io.full[3]); end
    for (int k = 11; k <= 14; k++) begin
      n_cmp++; if (io.out_data[3*W +: W] !== k) begin n_bad++; $display("FAIL pp_drain_%0d: got %0d expected %0d", k, io.out_data[3*W +: W], k); end
      drive('0, '0, 4'b1000);
    end
    n_cmp++; if (io.out_valid[3] !== 1'b0 || io.overflow[3] !== 1'b0)
      begin n_bad++; $display("FAIL pp_end: valid %b ovf %b expected 0/0", io.out_valid[3], io.overflow[3]); end
  endtask

  task automatic test_wrap_indep();
    logic [W-1:0] sent [$];
    logic [W-1:0] got [$];
    logic [M-1:0] g, r;
    logic [M*W-1:0] d;
    logic [W-1:0] w;
    int cyc;
    cyc = 0;
    while (got.size() < 20 && cyc < 200) begin
      r = {2'b00, cyc[0], 1'b0};
      g = 4'b0001;
      d = put(0, 32'hF000 + cyc);
      if (sent.size() < 20 && mq[1].size() < DEPTH - 1 && $urandom_range(0, 2) != 0) begin
        w = $urandom;
        g[1] = 1'b1;
        d[1*W +: W] = w;
        sent.push_back(w);
      end
      if (io.out_valid[1] && r[1]) got.push_back(io.out_data[1*W +: W]);
      drive(g, d, r);
      cyc++;
    end
    n_cmp++; if (got.size() != 20) begin n_bad++; $display("FAIL wrap_count: got %0d expected 20 (cycles %0d)", got.size(), cyc); end
    for (int i = 0; i < got.size() && i < sent.size(); i++) begin
      n_cmp++; if (got[i] !== sent[i]) begin n_bad++; $display("FAIL wrap_word%0d: got %h expected %h", i, got[i], sent[i]); end
    end
    // Port 0 started empty and was pushed every cycle with no pops.
    n_cmp++; if (io.drop_cnt[0 +: CNT_W] !== CNT_W'(2 + cyc - DEPTH))
      begin n_bad++; $display("FAIL wrap_p0_drops: got %0d expected %0d", io.drop_cnt[0 +: CNT_W], 2 + cyc - DEPTH); end
    n_cmp++; if (io.drop_cnt[1*CNT_W +: CNT_W] !== '0) begin n_bad++; $display("FAIL wrap_p1_drops: got %0d expected 0", io.drop_cnt[1*CNT_W +: CNT_W]); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 300; k++) drive(4'b0001, put(0, k), '0);
    n_cmp++; if (io.drop_cnt[0 +: CNT_W] !== 8'd255) begin n_bad++; $display("FAIL sat_p0: got %0d expected 255", io.drop_cnt[0 +: CNT_W]); end
    for (int m = 1; m < M; m++) begin
      n_cmp++; if (io.drop_cnt[m*CNT_W +: CNT_W] !== '0) begin n_bad++; $display("FAIL sat_other%0d: got %0d expected 0", m, io.drop_cnt[m*CNT_W +: CNT_W]); end
    end
    n_cmp++; if (io.full[0] !== 1'b1) begin n_bad++; $display("FAIL sat_full: got %b expected 1", io.full[0]); end
  endtask

  task automatic test_random();
    logic [M-1:0] g, r;
    logic [M*W-1:0] d;
    logic [W-1:0] exp_d;
    #2 rst = 1'b1;
    #1 model_reset();
    #2 rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      for (int m = 0; m < M; m++) begin
        g[m] = ($urandom_range(0, 3) != 0);
        r[m] = ($urandom_range(0, 2) == 0);
        d[m*W +: W] = $urandom;
      end
      drive(g, d, r);
      for (int m = 0; m < M; m++) begin
        exp_d = (mq[m].size() != 0) ? mq[m][0] : '0;
        n_cmp++; if (io.out_valid[m] !== (mq[m].size() != 0))
          begin n_bad++; $display("FAIL rnd_valid c%0d p%0d: got %b expected %b", c, m, io.out_valid[m], mq[m].size() != 0); end
        n_cmp++; if (io.out_data[m*W +: W] !== exp_d)
          begin n_bad++; $display("FAIL rnd_data c%0d p%0d: got %h expected %h", c, m, io.out_data[m*W +: W], exp_d); end
        n_cmp++; if (io.full[m] !== (mq[m].size() == DEPTH))
          begin n_bad++; $display("FAIL rnd_full c%0d p%0d: got %b expected %b", c, m, io.full[m], mq[m].size() == DEPTH); end
        n_cmp++; if (io.drop_cnt[m*CNT_W +: CNT_W] !== CNT_W'(mdrop[m]))
          begin n_bad++; $display("FAIL rnd_drop c%0d p%0d: got %0d expected %0d", c, m, io.drop_cnt[m*CNT_W +: CNT_W], mdrop[m]); end
        n_cmp++; if (io.overflow[m] !== movf[m])
          begin n_bad++; $display("FAIL rnd_ovf c%0d p%0d: got %b expected %b", c, m, io.overflow[m], movf[m]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drop();
    test_full_pushpop();
    test_wrap_indep();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
